// File: rtl/dmem_write_buffer.sv
// Line write buffer between D_cache and slow_memD; writes ack 2 cycles after request, full buffer stalls writes.
// Reads have priority over drains. Build option WBUF_FWD_EN: buffer hits forward data and misses bypass queued drains.
module dmem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         cache_read,
    input  logic         cache_write,
    input  logic [27:0]  cache_addr,
    input  logic [127:0] cache_wdata,
    output logic [127:0] cache_rdata,
    output logic         cache_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_RESP = 2'd2;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_WR   = 2'd1;
    localparam logic [1:0] M_RD   = 2'd2;

    logic [1:0]   r_c_state;
    logic [1:0]   r_m_state;
    logic [27:0]  r_addr [DEPTH];
    logic [127:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]  r_count;
    logic [27:0]  r_rd_addr;
    logic [127:0] r_rdata;
    logic [27:0]  r_mem_addr;
    logic [127:0] r_mem_wdata;

    logic          w_full;
    logic          w_rd_eligible;
    logic          w_hold_drain;
    logic          w_rd_go;
    logic          w_launch_wr;
    logic          w_head_busy;
    logic          w_pop;
    logic          w_push;
    logic          w_coal;
    logic          w_wr_hit;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_idx;
`ifdef WBUF_FWD_EN
    logic          w_rd_hit;
    logic [127:0]  w_rd_data;
`endif

    assign w_full = (r_count == (PW+1)'(DEPTH));

`ifdef WBUF_FWD_EN
    assign w_rd_eligible = 1'b1;
    // Keep memory free for a read that may follow a just-acked request.
    assign w_hold_drain  = (r_c_state == C_RESP) ||
                           ((r_c_state == C_IDLE) && cache_read && !cache_write);
`else
    assign w_rd_eligible = (r_count == '0);
    assign w_hold_drain  = 1'b0;
`endif

    assign w_rd_go     = (r_m_state == M_IDLE) && (r_c_state == C_WAIT) && w_rd_eligible;
    assign w_launch_wr = (r_m_state == M_IDLE) && !w_rd_go && (r_count != '0) && !w_hold_drain;
    // A head being launched this edge is already frozen, so writes to it must allocate anew.
    assign w_head_busy = (r_m_state == M_WR) || w_launch_wr;
    assign w_pop       = (r_m_state == M_WR) && mem_ready;

    always_comb begin
        w_wr_hit  = 1'b0;
        w_wr_idx  = '0;
        w_idx     = '0;
`ifdef WBUF_FWD_EN
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (((PW+1)'(k) < r_count) && (r_addr[w_idx] == cache_addr)) begin
                if (!((k == 0) && w_head_busy)) begin
                    w_wr_hit = 1'b1;
                    w_wr_idx = w_idx;
                end
`ifdef WBUF_FWD_EN
                w_rd_hit  = 1'b1;
                w_rd_data = r_data[w_idx];
`endif
            end
        end
    end

    assign w_coal = (r_c_state == C_IDLE) && cache_write && w_wr_hit;
    assign w_push = (r_c_state == C_IDLE) && cache_write && !w_wr_hit && !w_full;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_c_state <= C_IDLE;
            r_rd_addr <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_c_state)
                C_IDLE: begin
                    if (cache_write) begin
                        if (w_wr_hit || !w_full) begin
                            r_c_state <= C_RESP;
                        end
                    end else if (cache_read) begin
`ifdef WBUF_FWD_EN
                        if (w_rd_hit) begin
                            r_rdata   <= w_rd_data;
                            r_c_state <= C_RESP;
                        end else begin
                            r_rd_addr <= cache_addr;
                            r_c_state <= C_WAIT;
                        end
`else
                        r_rd_addr <= cache_addr;
                        r_c_state <= C_WAIT;
`endif
                    end
                end
                C_WAIT: begin
                    if ((r_m_state == M_RD) && mem_ready) begin
                        r_rdata   <= mem_rdata;
                        r_c_state <= C_RESP;
                    end
                end
                default: r_c_state <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage needs no reset: validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= cache_addr;
            r_data[r_tail] <= cache_wdata;
        end
        if (w_coal) begin
            r_data[w_wr_idx] <= cache_wdata;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_m_state   <= M_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_m_state)
                M_IDLE: begin
                    if (w_rd_go) begin
                        r_m_state  <= M_RD;
                        r_mem_addr <= r_rd_addr;
                    end else if (w_launch_wr) begin
                        r_m_state   <= M_WR;
                        r_mem_addr  <= r_addr[r_head];
                        r_mem_wdata <= r_data[r_head];
                    end
                end
                M_WR, M_RD: begin
                    if (mem_ready) begin
                        r_m_state   <= M_IDLE;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                default: r_m_state <= M_IDLE;
            endcase
        end
    end

    assign cache_ready = (r_c_state == C_RESP);
    assign cache_rdata = r_rdata;
    assign mem_read    = (r_m_state == M_RD);
    assign mem_write   = (r_m_state == M_WR);
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule
